// File: rtl/state_dump_scanner.sv
// state_dump_scanner: streams a snapshot of a register file, then a data-memory
// window, as valid/ready beats when a selectable trigger fires.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   en_i                    enables cycle counter and trigger evaluation
//   mode_i                  0 off, 1 manual (trig_i), 2 periodic (period_i), 3 cycle match (match_i)
//   reg_addr_o/reg_data_i   register read port (combinational data)
//   mem_addr_o/mem_data_i   memory word read port (combinational data)
//   out_*                   beat stream: data, kind (0 reg / 1 mem), index, last
//   busy_o                  scan in progress
//   cycle_cnt_o             free-running cycle count
//   dropped_o               saturating count of triggers lost while busy
module state_dump_scanner #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_N  = 32,
    parameter int unsigned MEM_N  = 32,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic              trig_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic [CNT_W-1:0]  match_i,
    output logic [IDX_W-1:0]  reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [IDX_W-1:0]  mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_kind_o,
    output logic [IDX_W-1:0]  out_idx_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [15:0]       dropped_o
);

    // S_LAST: every word captured, waiting for the final beat to be accepted
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REG  = 2'd1,
        S_MEM  = 2'd2,
        S_LAST = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_N - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_N - 1);
    localparam logic [15:0]      DROP_MAX = 16'hFFFF;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic                r_valid, w_valid_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic                r_kind, w_kind_nxt;
    logic [IDX_W-1:0]    r_oidx, w_oidx_nxt;
    logic                r_last, w_last_nxt;
    logic                r_busy, w_busy_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [15:0]         r_drop, w_drop_nxt;

    logic                w_trig;
    logic                w_fire;
    logic                w_can;
    logic                w_cap_reg;
    logic                w_cap_mem;

    assign w_fire = r_valid && out_ready_i;
    // A new word may be captured when the output slot is empty or being emptied
    assign w_can  = !r_valid || out_ready_i;

    // Trigger decode; periodic fires on the last count of each period
    always_comb begin
        w_trig = 1'b0;
        if (en_i) begin
            case (mode_i)
                2'd1:    w_trig = trig_i;
                2'd2:    w_trig = (period_i != '0) &&
                                  ((r_cnt % period_i) == (period_i - CNT_W'(1)));
                2'd3:    w_trig = (r_cnt == match_i);
                default: w_trig = 1'b0;
            endcase
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_kind_nxt  = r_kind;
        w_oidx_nxt  = r_oidx;
        w_valid_nxt = r_valid && !out_ready_i;
        w_last_nxt  = r_last && !w_fire;
        w_cnt_nxt   = en_i ? (r_cnt + CNT_W'(1)) : r_cnt;
        w_drop_nxt  = r_drop;
        w_cap_reg   = 1'b0;
        w_cap_mem   = 1'b0;

        // Any trigger seen outside IDLE is lost, including the last-accept cycle
        if (w_trig && (r_state != S_IDLE) && (r_drop != DROP_MAX)) begin
            w_drop_nxt = r_drop + 16'd1;
        end

        case (r_state)
            S_IDLE:  w_cap_reg = w_trig;    // index is parked at 0, so capture at once
            S_REG:   w_cap_reg = w_can;
            S_MEM:   w_cap_mem = w_can;
            S_LAST:  if (w_fire) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_cap_reg) begin
            w_data_nxt  = reg_data_i;
            w_kind_nxt  = 1'b0;
            w_oidx_nxt  = r_idx;
            w_valid_nxt = 1'b1;
            w_last_nxt  = 1'b0;
            if (r_idx == REG_LAST) begin
                w_state_nxt = S_MEM;
                w_idx_nxt   = '0;
            end else begin
                w_state_nxt = S_REG;
                w_idx_nxt   = r_idx + IDX_W'(1);
            end
        end

        if (w_cap_mem) begin
            w_data_nxt  = mem_data_i;
            w_kind_nxt  = 1'b1;
            w_oidx_nxt  = r_idx;
            w_valid_nxt = 1'b1;
            w_last_nxt  = (r_idx == MEM_LAST);
            if (r_idx == MEM_LAST) begin
                w_state_nxt = S_LAST;
                w_idx_nxt   = '0;
            end else begin
                w_idx_nxt   = r_idx + IDX_W'(1);
            end
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_kind  <= 1'b0;
            r_oidx  <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_kind  <= w_kind_nxt;
            r_oidx  <= w_oidx_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    assign reg_addr_o  = r_idx;
    assign mem_addr_o  = r_idx;
    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;
    assign out_kind_o  = r_kind;
    assign out_idx_o   = r_oidx;
    assign out_last_o  = r_last;
    assign busy_o      = r_busy;
    assign cycle_cnt_o = r_cnt;
    assign dropped_o   = r_drop;

endmodule

// File: tb/tb_state_dump_scanner.sv
// tb_state_dump_scanner: scoreboard bench for state_dump_scanner with a
// 4-register / 4-word source and an 8-bit cycle counter so wrap is reachable.
module tb_state_dump_scanner;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_N  = 4;
    localparam int unsigned MEM_N  = 4;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned CNT_W  = 8;

    typedef struct packed {
        logic              last;
        logic              kind;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              en_i;
    logic [1:0]        mode_i;
    logic              trig_i;
    logic [CNT_W-1:0]  period_i;
    logic [CNT_W-1:0]  match_i;
    logic [IDX_W-1:0]  reg_addr_o;
    logic [DATA_W-1:0] reg_data_i;
    logic [IDX_W-1:0]  mem_addr_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic              out_kind_o;
    logic [IDX_W-1:0]  out_idx_o;
    logic              out_last_o;
    logic              busy_o;
    logic [CNT_W-1:0]  cycle_cnt_o;
    logic [15:0]       dropped_o;

    always #5 clk = ~clk;

    // Source model: reg[i] = i+10, mem[i] = i+100
    assign reg_data_i = DATA_W'(reg_addr_o) + DATA_W'(10);
    assign mem_data_i = DATA_W'(mem_addr_o) + DATA_W'(100);

    state_dump_scanner #(
        .DATA_W(DATA_W), .REG_N(REG_N), .MEM_N(MEM_N), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i), .trig_i(trig_i),
        .period_i(period_i), .match_i(match_i),
        .reg_addr_o(reg_addr_o), .reg_data_i(reg_data_i),
        .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_kind_o(out_kind_o), .out_idx_o(out_idx_o),
        .out_last_o(out_last_o), .busy_o(busy_o), .cycle_cnt_o(cycle_cnt_o),
        .dropped_o(dropped_o)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    beat_t w_cur;
    beat_t held_beat;
    logic  held = 1'b0;

    assign w_cur = {out_last_o, out_kind_o, out_idx_o, out_data_o};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_snapshot();
        beat_t b;
        for (int i = 0; i < int'(REG_N); i++) begin
            b = {1'b0, 1'b0, IDX_W'(i), DATA_W'(i + 10)};
            exp_q.push_back(b);
        end
        for (int i = 0; i < int'(MEM_N); i++) begin
            b = {(i == int'(MEM_N) - 1), 1'b1, IDX_W'(i), DATA_W'(i + 100)};
            exp_q.push_back(b);
        end
    endtask

    // Monitor: checks every accepted beat against the queue and beat stability while stalled
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (held && out_valid_o) chk("hold_stable", 64'(w_cur), 64'(held_beat));
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat_q_size", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'(w_cur), 64'(e));
                end
            end
            held      = out_valid_o && !out_ready_i;
            held_beat = w_cur;
        end
    end

    task automatic do_reset(input string name);
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk({name, "_rst_valid"}, 64'(out_valid_o), 64'd0);
        chk({name, "_rst_busy"},  64'(busy_o),      64'd0);
        chk({name, "_rst_cnt"},   64'(cycle_cnt_o), 64'd0);
        chk({name, "_rst_drop"},  64'(dropped_o),   64'd0);
        chk({name, "_rst_addr"},  64'(reg_addr_o),  64'd0);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || busy_o) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_idle"},    64'(busy_o),       64'd0);
    endtask

    task automatic pulse_trig();
        @(posedge clk);
        #1 trig_i = 1'b1;
        @(posedge clk);
        #1 trig_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bit hit;
        rst_i = 1'b1; en_i = 1'b0; mode_i = 2'd0; trig_i = 1'b0;
        period_i = '0; match_i = '0; out_ready_i = 1'b1;

        // Manual trigger, ready held: 8 consecutive beats, busy drops the cycle after
        en_i = 1'b1; mode_i = 2'd1;
        do_reset("s1");
        repeat (4) @(posedge clk);
        push_snapshot();
        pulse_trig();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("s1_valid_c%0d", k), 64'(out_valid_o), 64'(k <= 8));
            chk($sformatf("s1_busy_c%0d", k),  64'(busy_o),      64'(k <= 8));
        end
        wait_drain("s1");
        chk("s1_dropped", 64'(dropped_o), 64'd0);

        // Same scan with ready toggling 1,0,0,...
        push_snapshot();
        @(posedge clk);
        #1 trig_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1 trig_i = 1'b0;
            out_ready_i = (c % 3 == 0);
        end
        out_ready_i = 1'b1;
        wait_drain("s2");

        // Periodic, period 20: snapshots at counts 19, 39, 59
        mode_i = 2'd2; period_i = 8'd20;
        do_reset("s3");
        repeat (3) push_snapshot();
        hit = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (cycle_cnt_o == 8'd19) chk("s3_busy_at19", 64'(busy_o), 64'd0);
            if (cycle_cnt_o == 8'd20) chk("s3_busy_at20", 64'(busy_o), 64'd1);
            if (cycle_cnt_o == 8'd70) begin hit = 1'b1; break; end
        end
        chk("s3_reached", 64'(hit), 64'd1);
        mode_i = 2'd0;
        wait_drain("s3");
        chk("s3_dropped", 64'(dropped_o), 64'd0);

        // Periodic, period 3: snapshots start at 2, 11, 20, 29; two drops each
        mode_i = 2'd2; period_i = 8'd3;
        do_reset("s4");
        repeat (4) push_snapshot();
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (cycle_cnt_o == 8'd36) begin mode_i = 2'd0; hit = 1'b1; break; end
        end
        chk("s4_reached", 64'(hit), 64'd1);
        wait_drain("s4");
        chk("s4_dropped", 64'(dropped_o), 64'd8);

        // Reset mid-scan at memory index 2, then a fresh scan from register 0
        mode_i = 2'd1;
        push_snapshot();
        @(posedge clk);
        #1 trig_i = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1 trig_i = 1'b0;
            if (out_valid_o && out_kind_o && out_idx_o == 8'd2) begin
                rst_i = 1'b1; out_ready_i = 1'b0; hit = 1'b1; break;
            end
        end
        chk("s6_reached_mem2", 64'(hit), 64'd1);
        @(posedge clk);
        #1 rst_i = 1'b0; out_ready_i = 1'b1;
        @(negedge clk);
        chk("s6_valid", 64'(out_valid_o), 64'd0);
        chk("s6_busy",  64'(busy_o),      64'd0);
        chk("s6_cnt",   64'(cycle_cnt_o), 64'd0);
        chk("s6_drop",  64'(dropped_o),   64'd0);
        chk("s6_q_left", 64'(exp_q.size()), 64'd2);
        exp_q.delete();
        push_snapshot();
        pulse_trig();
        wait_drain("s6");

        // Cycle match at the counter's maximum, run past the wrap: one snapshot only
        mode_i = 2'd3; match_i = 8'hFF;
        do_reset("s5");
        push_snapshot();
        seen = 1'b0;
        hit  = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!seen && cycle_cnt_o == 8'hFF) begin
                chk("s5_busy_at_match", 64'(busy_o), 64'd0);
                @(negedge clk);
                chk("s5_cnt_after_match", 64'(cycle_cnt_o), 64'd0);
                chk("s5_busy_after_match", 64'(busy_o), 64'd1);
                seen = 1'b1;
            end
            if (seen && cycle_cnt_o == 8'd40) begin hit = 1'b1; break; end
        end
        chk("s5_wrapped", 64'(hit), 64'd1);
        wait_drain("s5");
        chk("s5_dropped", 64'(dropped_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
